// File: rtl/glob_cmd_scheduler_if.sv
// rtl/glob_cmd_scheduler_if.sv - host command port and per-controller issue buses of the global command scheduler
interface glob_cmd_scheduler_if #(
  parameter int address_vector_width = 8,
  parameter int sample_address_width = 8,
  parameter int fifo_depth           = 4
);
  localparam int count_width = $clog2(fifo_depth) + 1;

  logic                            cmd_valid;
  logic                            cmd_ready;
  logic [1:0]                      cmd_type;
  logic [1:0]                      cmd_target;
  logic [sample_address_width-1:0] cmd_arg0;
  logic [sample_address_width-1:0] cmd_arg1;
  logic [address_vector_width-1:0] cmd_dest;

  logic [3:0]                      glob_valid;
  logic [sample_address_width-1:0] glob_delay;
  logic [address_vector_width-1:0] glob_dest_addr;
  logic [3:0]                      pf_valid;
  logic [sample_address_width-1:0] pf_start;
  logic [sample_address_width-1:0] pf_stop;
  logic [address_vector_width-1:0] pf_dest;
  logic [3:0]                      write_flag;
  logic [3:0]                      pf_busy;
  logic                            err;
  logic [count_width-1:0]          fifo_count;

  modport master (
    output cmd_valid, cmd_type, cmd_target, cmd_arg0, cmd_arg1, cmd_dest,
    input  cmd_ready, glob_valid, glob_delay, glob_dest_addr, pf_valid, pf_start,
           pf_stop, pf_dest, write_flag, pf_busy, err, fifo_count
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_target, cmd_arg0, cmd_arg1, cmd_dest,
    output cmd_ready, glob_valid, glob_delay, glob_dest_addr, pf_valid, pf_start,
           pf_stop, pf_dest, write_flag, pf_busy, err, fifo_count
  );
endinterface

// File: rtl/glob_cmd_scheduler.sv
// rtl/glob_cmd_scheduler.sv - in-order command FIFO issuing config/prefetch/write strobes to four local controllers
module glob_cmd_scheduler #(
  parameter int address_vector_width = 8,
  parameter int sample_address_width = 8,
  parameter int fifo_depth           = 4,
  parameter int pf_gap               = 2
) (
  input logic               CLK,
  input logic               reset,
  glob_cmd_scheduler_if.slave bus
);
  localparam int saw         = sample_address_width;
  localparam int avw         = address_vector_width;
  localparam int ptr_width   = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int count_width = $clog2(fifo_depth) + 1;
  localparam int busy_width  = sample_address_width + 2;

  typedef enum logic [1:0] {
    CMD_CONFIG   = 2'b00,
    CMD_PREFETCH = 2'b01,
    CMD_WRITE    = 2'b10,
    CMD_RESERVED = 2'b11
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e      kind;
    logic [1:0]     target;
    logic [saw-1:0] arg0;
    logic [saw-1:0] arg1;
    logic [avw-1:0] dest;
  } cmd_t;

  cmd_t                 fifo_mem [fifo_depth];
  logic [ptr_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [ptr_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [count_width-1:0] count_q, count_d;
  logic [3:0][busy_width-1:0] busy_q, busy_d;

  logic [3:0]     glob_valid_q, glob_valid_d;
  logic [saw-1:0] glob_delay_q, glob_delay_d;
  logic [avw-1:0] glob_dest_q, glob_dest_d;
  logic [3:0]     pf_valid_q, pf_valid_d;
  logic [saw-1:0] pf_start_q, pf_start_d;
  logic [saw-1:0] pf_stop_q, pf_stop_d;
  logic [avw-1:0] pf_dest_q, pf_dest_d;
  logic [3:0]     write_flag_q, write_flag_d;
  logic           err_q, err_d;

  cmd_t            head_cmd;
  cmd_t            push_cmd;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            head_blocked;
  logic [saw-1:0]  pf_span;
  logic [busy_width-1:0] pf_len;

  assign fifo_full  = (count_q == count_width'(fifo_depth));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.cmd_valid && !fifo_full;

  assign push_cmd.kind   = cmd_kind_e'(bus.cmd_type);
  assign push_cmd.target = bus.cmd_target;
  assign push_cmd.arg0   = bus.cmd_arg0;
  assign push_cmd.arg1   = bus.cmd_arg1;
  assign push_cmd.dest   = bus.cmd_dest;

  assign head_cmd = fifo_mem[rd_ptr_q];

  // Only a prefetch whose target is still streaming holds the head; everything behind waits in order.
  assign head_blocked = (head_cmd.kind == CMD_PREFETCH) && (busy_q[head_cmd.target] != '0);
  assign pop          = !fifo_empty && !head_blocked;

  // Span wraps modulo the sample address space, so stop < start is a long window, not a negative one.
  assign pf_span = head_cmd.arg1 - head_cmd.arg0;
  assign pf_len  = busy_width'(pf_span) + busy_width'(1) + busy_width'(pf_gap);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + ptr_width'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ptr_width'(1) : rd_ptr_q;
    count_d  = count_q + count_width'(push) - count_width'(pop);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      busy_d[i] = (busy_q[i] != '0) ? busy_q[i] - busy_width'(1) : busy_q[i];
    end
    if (pop && head_cmd.kind == CMD_PREFETCH) begin
      busy_d[head_cmd.target] = pf_len;
    end
  end

  always_comb begin
    glob_valid_d = '0;
    glob_delay_d = '0;
    glob_dest_d  = '0;
    pf_valid_d   = '0;
    pf_start_d   = '0;
    pf_stop_d    = '0;
    pf_dest_d    = '0;
    write_flag_d = '0;
    err_d        = 1'b0;
    if (pop) begin
      case (head_cmd.kind)
        CMD_CONFIG: begin
          glob_valid_d[head_cmd.target] = 1'b1;
          glob_delay_d                  = head_cmd.arg0;
          glob_dest_d                   = head_cmd.dest;
        end
        CMD_PREFETCH: begin
          pf_valid_d[head_cmd.target] = 1'b1;
          pf_start_d                  = head_cmd.arg0;
          pf_stop_d                   = head_cmd.arg1;
          pf_dest_d                   = head_cmd.dest;
        end
        CMD_WRITE: begin
          write_flag_d[head_cmd.target] = 1'b1;
        end
        CMD_RESERVED: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_cmd;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      busy_q       <= '0;
      glob_valid_q <= '0;
      glob_delay_q <= '0;
      glob_dest_q  <= '0;
      pf_valid_q   <= '0;
      pf_start_q   <= '0;
      pf_stop_q    <= '0;
      pf_dest_q    <= '0;
      write_flag_q <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      glob_valid_q <= glob_valid_d;
      glob_delay_q <= glob_delay_d;
      glob_dest_q  <= glob_dest_d;
      pf_valid_q   <= pf_valid_d;
      pf_start_q   <= pf_start_d;
      pf_stop_q    <= pf_stop_d;
      pf_dest_q    <= pf_dest_d;
      write_flag_q <= write_flag_d;
      err_q        <= err_d;
    end
  end

  assign bus.cmd_ready      = !fifo_full;
  assign bus.fifo_count     = count_q;
  assign bus.glob_valid     = glob_valid_q;
  assign bus.glob_delay     = glob_delay_q;
  assign bus.glob_dest_addr = glob_dest_q;
  assign bus.pf_valid       = pf_valid_q;
  assign bus.pf_start       = pf_start_q;
  assign bus.pf_stop        = pf_stop_q;
  assign bus.pf_dest        = pf_dest_q;
  assign bus.write_flag     = write_flag_q;
  assign bus.err            = err_q;

  for (genvar g = 0; g < 4; g++) begin : g_busy
    assign bus.pf_busy[g] = (busy_q[g] != '0);
  end
endmodule

// File: tb/tb_glob_cmd_scheduler.sv
// tb/tb_glob_cmd_scheduler.sv - directed and random stimulus for glob_cmd_scheduler against a per-command timeline model
module tb_glob_cmd_scheduler;
  localparam int AVW   = 8;
  localparam int SAW   = 8;
  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int MAXC  = 2048;

  logic CLK   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   errs  = 0;
  int   checks = 0;

  glob_cmd_scheduler_if #(.address_vector_width(AVW), .sample_address_width(SAW), .fifo_depth(DEPTH)) bus ();

  glob_cmd_scheduler #(
    .address_vector_width(AVW), .sample_address_width(SAW), .fifo_depth(DEPTH), .pf_gap(GAP)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Model: each accepted command gets an accept edge and an issue edge computed from ordering and busy windows.
  int             m_kind [MAXC];
  logic [1:0]     m_tgt  [MAXC];
  logic [SAW-1:0] m_a0   [MAXC];
  logic [SAW-1:0] m_a1   [MAXC];
  logic [AVW-1:0] m_dst  [MAXC];
  int             m_acc  [MAXC];
  int             m_iss  [MAXC];
  int             m_len  [MAXC];
  int             n_cmd    = 0;
  int             base     = 0;
  int             last_iss = -1;
  int             pf_free [4];
  int             pf3_edges [$];
  int             busy0_cycles = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    base     = n_cmd;
    last_iss = -1;
    for (int t = 0; t < 4; t++) pf_free[t] = 0;
  endtask

  task automatic model_push(input logic [1:0] k, input logic [1:0] t, input logic [SAW-1:0] a0,
                            input logic [SAW-1:0] a1, input logic [AVW-1:0] d);
    logic [SAW-1:0] span;
    int iss;
    if (n_cmd >= MAXC) $fatal(1, "FAIL model_capacity exceeded");
    span = a1 - a0;
    m_kind[n_cmd] = int'(k);
    m_tgt[n_cmd]  = t;
    m_a0[n_cmd]   = a0;
    m_a1[n_cmd]   = a1;
    m_dst[n_cmd]  = d;
    m_acc[n_cmd]  = cyc + 1;
    iss = (cyc + 2 > last_iss + 1) ? cyc + 2 : last_iss + 1;
    m_len[n_cmd] = int'(span) + 1 + GAP;
    if (k == 2'b01) begin
      if (pf_free[t] > iss) iss = pf_free[t];
      pf_free[t] = iss + m_len[n_cmd] + 1;
    end
    m_iss[n_cmd] = iss;
    last_iss = iss;
    n_cmd++;
  endtask

  task automatic check_outputs(output int cnt);
    logic [3:0]     gv, pv, wf, busy;
    logic [SAW-1:0] dly, ps, pe;
    logic [AVW-1:0] gd, pd;
    logic           er;
    gv = '0; pv = '0; wf = '0; busy = '0;
    dly = '0; ps = '0; pe = '0; gd = '0; pd = '0; er = 1'b0;
    cnt = 0;
    for (int i = base; i < n_cmd; i++) begin
      if (m_acc[i] <= cyc) cnt++;
      if (m_iss[i] <= cyc) cnt--;
      if (m_iss[i] == cyc) begin
        case (m_kind[i])
          0: begin gv[m_tgt[i]] = 1'b1; dly = m_a0[i]; gd = m_dst[i]; end
          1: begin pv[m_tgt[i]] = 1'b1; ps = m_a0[i]; pe = m_a1[i]; pd = m_dst[i]; end
          2: wf[m_tgt[i]] = 1'b1;
          default: er = 1'b1;
        endcase
      end
      if (m_kind[i] == 1 && m_iss[i] <= cyc && cyc < m_iss[i] + m_len[i]) busy[m_tgt[i]] = 1'b1;
    end
    chk("glob_valid", bus.glob_valid, gv);
    chk("glob_delay", bus.glob_delay, dly);
    chk("glob_dest_addr", bus.glob_dest_addr, gd);
    chk("pf_valid", bus.pf_valid, pv);
    chk("pf_start", bus.pf_start, ps);
    chk("pf_stop", bus.pf_stop, pe);
    chk("pf_dest", bus.pf_dest, pd);
    chk("write_flag", bus.write_flag, wf);
    chk("err", bus.err, er);
    chk("pf_busy", bus.pf_busy, busy);
    chk("fifo_count", bus.fifo_count, cnt);
    chk("cmd_ready", bus.cmd_ready, cnt < DEPTH);
  endtask

  task automatic step(input bit v, input logic [1:0] k, input logic [1:0] t, input logic [SAW-1:0] a0,
                      input logic [SAW-1:0] a1, input logic [AVW-1:0] d, output bit accepted);
    int cnt;
    @(negedge CLK);
    check_outputs(cnt);
    if (bus.pf_valid[3]) pf3_edges.push_back(cyc);
    if (bus.pf_busy[0]) busy0_cycles++;
    accepted = v && (cnt < DEPTH);
    bus.cmd_valid  = v;
    bus.cmd_type   = k;
    bus.cmd_target = t;
    bus.cmd_arg0   = a0;
    bus.cmd_arg1   = a1;
    bus.cmd_dest   = d;
    if (accepted) model_push(k, t, a0, a1, d);
  endtask

  task automatic send(input logic [1:0] k, input logic [1:0] t, input logic [SAW-1:0] a0,
                      input logic [SAW-1:0] a1, input logic [AVW-1:0] d);
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 300 && !acc; n++) step(1'b1, k, t, a0, a1, d, acc);
    chk("send_accepted", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, '0, '0, '0, acc);
  endtask

  initial begin
    int cnt;
    int r;
    logic [1:0] k;
    logic [SAW-1:0] a0;
    bus.cmd_valid = 1'b0; bus.cmd_type = '0; bus.cmd_target = '0;
    bus.cmd_arg0 = '0; bus.cmd_arg1 = '0; bus.cmd_dest = '0;
    model_reset();

    repeat (3) begin
      @(negedge CLK);
      check_outputs(cnt);
    end
    reset = 1'b1;

    send(2'b00, 2'd2, 8'h19, 8'h00, 8'h08);
    idle(3);

    pf3_edges.delete();
    send(2'b01, 2'd3, 8'h50, 8'h60, 8'h11);
    send(2'b01, 2'd3, 8'h50, 8'h60, 8'h22);
    send(2'b00, 2'd0, 8'h33, 8'h00, 8'h44);
    idle(30);
    chk("pf3_strobe_count", pf3_edges.size(), 2);
    if (pf3_edges.size() >= 2) chk("pf3_spacing", pf3_edges[1] - pf3_edges[0], 20);

    busy0_cycles = 0;
    send(2'b01, 2'd0, 8'hF0, 8'h0F, 8'h55);
    send(2'b01, 2'd1, 8'h01, 8'h02, 8'h66);
    idle(45);
    chk("wrap_busy_cycles", busy0_cycles, 34);

    send(2'b01, 2'd2, 8'h00, 8'h40, 8'h01);
    send(2'b01, 2'd2, 8'h10, 8'h11, 8'h02);
    send(2'b00, 2'd0, 8'h03, 8'h00, 8'h04);
    send(2'b00, 2'd1, 8'h05, 8'h00, 8'h06);
    send(2'b00, 2'd3, 8'h07, 8'h00, 8'h08);
    idle(1);
    chk("full_cmd_ready", bus.cmd_ready, 1'b0);
    chk("full_fifo_count", bus.fifo_count, 4);
    send(2'b00, 2'd2, 8'h09, 8'h00, 8'h0A);
    idle(25);

    send(2'b11, 2'd1, 8'hAA, 8'hBB, 8'hCC);
    send(2'b10, 2'd0, 8'h00, 8'h00, 8'h00);
    idle(4);

    send(2'b01, 2'd1, 8'h00, 8'h30, 8'h10);
    send(2'b01, 2'd1, 8'h00, 8'h01, 8'h20);
    send(2'b00, 2'd0, 8'h01, 8'h00, 8'h30);
    send(2'b00, 2'd2, 8'h02, 8'h00, 8'h40);
    @(negedge CLK);
    chk("pre_reset_count", bus.fifo_count, 3);
    chk("pre_reset_busy", bus.pf_busy[1], 1'b1);
    bus.cmd_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_strobes", {bus.glob_valid, bus.pf_valid, bus.write_flag, bus.pf_busy, bus.err}, 0);
    chk("rst_buses", {bus.glob_delay, bus.glob_dest_addr, bus.pf_start, bus.pf_stop, bus.pf_dest}, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 1'b1;
    send(2'b00, 2'd1, 8'h5A, 8'h00, 8'hA5);
    idle(3);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      k  = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      a0 = SAW'($urandom);
      send(k, 2'($urandom_range(0, 3)), a0, a0 + SAW'($urandom_range(0, 20)), AVW'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(80);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
